// File: rtl/wb_secded_regfile.sv
// Wishbone register file of DEPTH SEC-DED protected words with a background scrubber and a fault-injection port.
// Ack is registered one cycle after the request; the scrubber yields to bus storage traffic and never stalls the bus.
module wb_secded_regfile #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          DEPTH        = 8,
    parameter int          SCRUB_PERIOD = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        inj_valid_i,
    input  logic [4:0]  inj_addr_i,
    input  logic [38:0] inj_mask_i,
    output logic        irq_o,
    output logic [1:0]  ecc_evt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(SCRUB_PERIOD - 1);

    function automatic logic [5:0] f_syndrome(input logic [38:0] cw);
        logic [5:0] s;
        s = '0;
        for (int i = 1; i < 39; i++) begin
            if (cw[i]) s = s ^ 6'(i);
        end
        return s;
    endfunction

    // Data fills the non-power-of-two positions; check bits are then chosen to zero the syndrome.
    function automatic logic [38:0] f_encode(input logic [31:0] d);
        logic [38:0] cw;
        logic [5:0]  s;
        int          k;
        cw = '0;
        k  = 0;
        for (int i = 1; i < 39; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[k];
                k = k + 1;
            end
        end
        s = f_syndrome(cw);
        for (int j = 0; j < 6; j++) begin
            cw[1 << j] = s[j];
        end
        cw[0] = ^cw[38:1];
        return cw;
    endfunction

    function automatic logic [31:0] f_extract(input logic [38:0] cw);
        logic [31:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int i = 1; i < 39; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = cw[i];
                k = k + 1;
            end
        end
        return d;
    endfunction

    logic [38:0]   r_mem [DEPTH];
    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_irq;
    logic [1:0]    r_evt;
    logic [15:0]   r_cnt_corr;
    logic [15:0]   r_cnt_unc;
    logic [1:0]    r_ctrl;
    logic [TW-1:0] r_tmr;
    logic [AW-1:0] r_scrub_ptr;
    logic          r_pend;

    logic          w_hit;
    logic          w_req;
    logic [5:0]    w_off;
    logic          w_is_stor;
    logic          w_bus_stor;
    logic [AW-1:0] w_bus_idx;
    logic          w_stor_rd;
    logic          w_stor_wr;
    logic          w_st_wr;
    logic          w_ctrl_wr;
    logic          w_tc;
    logic          w_scrub_go;
    logic [AW-1:0] w_dec_idx;
    logic [38:0]   w_raw;
    logic [5:0]    w_syn;
    logic          w_par;
    logic [38:0]   w_fixed;
    logic          w_corr_dec;
    logic          w_unc_dec;
    logic [31:0]   w_data;
    logic [31:0]   w_merged;
    logic          w_chk;
    logic          w_ev_corr;
    logic          w_ev_unc;
    logic          w_wr_en;
    logic [38:0]   w_wr_dat;
    logic [AW-1:0] w_inj_idx;
    logic          w_inj_ok;
    logic          w_unused;

    assign w_hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_req      = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
    assign w_off      = wbs_adr_i[7:2];
    assign w_is_stor  = ~w_off[5] && ({1'b0, w_off[4:0]} < 6'(DEPTH));
    assign w_bus_stor = w_req & w_is_stor;
    assign w_bus_idx  = wbs_adr_i[AW+1:2];
    assign w_stor_rd  = w_bus_stor & ~wbs_we_i;
    assign w_stor_wr  = w_bus_stor & wbs_we_i & (|wbs_sel_i);
    assign w_st_wr    = w_req & wbs_we_i & (w_off == 6'h20);
    assign w_ctrl_wr  = w_req & wbs_we_i & (w_off == 6'h21) & wbs_sel_i[0];

    // A step that lands on a bus storage cycle is held in r_pend and retried on the next free cycle.
    assign w_tc       = r_ctrl[0] & (r_tmr == TMR_LAST);
    assign w_scrub_go = r_ctrl[0] & (w_tc | r_pend) & ~w_bus_stor;
    assign w_dec_idx  = w_bus_stor ? w_bus_idx : r_scrub_ptr;

    assign w_raw = r_mem[w_dec_idx];
    assign w_syn = f_syndrome(w_raw);
    assign w_par = ^w_raw;

    always_comb begin
        w_fixed    = w_raw;
        w_corr_dec = 1'b0;
        w_unc_dec  = 1'b0;
        if (w_syn == 6'd0) begin
            if (w_par) begin
                w_fixed[0] = ~w_raw[0];
                w_corr_dec = 1'b1;
            end
        end else if (!w_par || (w_syn > 6'd38)) begin
            w_unc_dec = 1'b1;
        end else begin
            w_fixed[w_syn] = ~w_raw[w_syn];
            w_corr_dec     = 1'b1;
        end
    end

    assign w_data = f_extract(w_fixed);

    always_comb begin
        w_merged = w_data;
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) w_merged[8*b +: 8] = wbs_dat_i[8*b +: 8];
        end
    end

    assign w_chk     = w_stor_rd | w_stor_wr | w_scrub_go;
    assign w_ev_corr = w_chk & w_corr_dec;
    assign w_ev_unc  = w_chk & w_unc_dec;
    assign w_wr_en   = w_stor_wr | w_ev_corr;
    assign w_wr_dat  = w_stor_wr ? f_encode(w_merged) : w_fixed;
    assign w_inj_idx = inj_addr_i[AW-1:0];
    assign w_inj_ok  = inj_valid_i & ~(w_wr_en & (w_dec_idx == w_inj_idx));
    assign w_unused  = ^{wbs_adr_i[1:0], inj_addr_i};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_inj_ok) r_mem[w_inj_idx] <= r_mem[w_inj_idx] ^ inj_mask_i;
            if (w_wr_en)  r_mem[w_dec_idx] <= w_wr_dat;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req && !wbs_we_i) begin
                if (w_is_stor)            r_dat <= w_data;
                else if (w_off == 6'h20)  r_dat <= {r_cnt_unc, r_cnt_corr};
                else if (w_off == 6'h21)  r_dat <= {30'd0, r_ctrl};
                else                      r_dat <= '0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ctrl     <= 2'b01;
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
            r_irq      <= 1'b0;
            r_evt      <= '0;
        end else begin
            r_evt <= {w_ev_unc, w_ev_corr};
            if (w_ctrl_wr) r_ctrl <= wbs_dat_i[1:0];
            if (w_st_wr) begin
                r_cnt_corr <= '0;
                r_cnt_unc  <= '0;
                r_irq      <= 1'b0;
            end else begin
                if (w_ev_corr && (r_cnt_corr != 16'hFFFF)) r_cnt_corr <= r_cnt_corr + 16'd1;
                if (w_ev_unc && (r_cnt_unc != 16'hFFFF))   r_cnt_unc  <= r_cnt_unc + 16'd1;
                if (w_ev_unc && r_ctrl[1])                 r_irq      <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_tmr       <= '0;
            r_scrub_ptr <= '0;
            r_pend      <= 1'b0;
        end else if (!r_ctrl[0]) begin
            r_pend <= 1'b0;
        end else begin
            r_tmr <= w_tc ? '0 : r_tmr + TW'(1);
            if (w_scrub_go) begin
                r_pend      <= 1'b0;
                r_scrub_ptr <= r_scrub_ptr + AW'(1);
            end else if (w_tc) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;
    assign ecc_evt_o = r_evt;
endmodule
